// File: rtl/ham_15_11_syndrome_decoder.sv
// Hamming(15,11) receive decoder: syndrome in stage 1, single-bit correction in stage 2.
// Optional error statistics counters are enabled with the macro HAM_DEC_STATS_EN.
module ham_15_11_syndrome_decoder #(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [14:0]       c_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [10:0]       d_out,
   output logic              err_det,
   output logic [3:0]        err_pos
`ifdef HAM_DEC_STATS_EN
   ,
   output logic [CNT_W-1:0]  cnt_corr,
   output logic [CNT_W-1:0]  cnt_total
`endif
);

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end

   // Handshake: a word moves on valid && ready; a stage may load whenever it is
   // empty or its contents leave in the same cycle, so ready never looks at valid.
   logic        s2_adv;
   logic        s1_adv;
   logic        accept;

   logic        s1_vld_q, s1_vld_d;
   logic [14:0] s1_c_q,   s1_c_d;
   logic [3:0]  s1_syn_q, s1_syn_d;

   logic        s2_vld_q, s2_vld_d;
   logic [10:0] s2_d_q,   s2_d_d;
   logic        s2_det_q, s2_det_d;
   logic [3:0]  s2_pos_q, s2_pos_d;

   logic [3:0]  syn_in;
   logic [14:0] flip;
   logic [14:0] corr;

   // Each syndrome bit checks the positions (i+1) that have that bit set.
   assign syn_in = {^(c_in & 15'h7F80), ^(c_in & 15'h7878),
                    ^(c_in & 15'h6666), ^(c_in & 15'h5555)};

   always_comb begin
      flip = '0;
      if (s1_syn_q != 4'd0) begin
         flip = 15'd1 << (s1_syn_q - 4'd1);
      end
      corr = s1_c_q ^ flip;
   end

   always_comb begin
      s2_adv = ~s2_vld_q | out_ready;
      s1_adv = ~s1_vld_q | s2_adv;
      accept = in_valid & s1_adv;

      s1_vld_d = s1_vld_q;
      s1_c_d   = s1_c_q;
      s1_syn_d = s1_syn_q;
      if (accept) begin
         s1_vld_d = 1'b1;
         s1_c_d   = c_in;
         s1_syn_d = syn_in;
      end else if (s2_adv) begin
         s1_vld_d = 1'b0;
      end

      s2_vld_d = s2_vld_q;
      s2_d_d   = s2_d_q;
      s2_det_d = s2_det_q;
      s2_pos_d = s2_pos_q;
      if (s1_vld_q && s2_adv) begin
         s2_vld_d = 1'b1;
         s2_d_d   = {corr[14:8], corr[6:4], corr[2]};
         s2_det_d = (s1_syn_q != 4'd0);
         s2_pos_d = s1_syn_q;
      end else if (out_ready) begin
         s2_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q <= 1'b0;
         s1_c_q   <= '0;
         s1_syn_q <= '0;
         s2_vld_q <= 1'b0;
         s2_d_q   <= '0;
         s2_det_q <= 1'b0;
         s2_pos_q <= '0;
      end else begin
         s1_vld_q <= s1_vld_d;
         s1_c_q   <= s1_c_d;
         s1_syn_q <= s1_syn_d;
         s2_vld_q <= s2_vld_d;
         s2_d_q   <= s2_d_d;
         s2_det_q <= s2_det_d;
         s2_pos_q <= s2_pos_d;
      end
   end

   assign in_ready  = s1_adv;
   assign out_valid = s2_vld_q;
   assign d_out     = s2_d_q;
   assign err_det   = s2_det_q;
   assign err_pos   = s2_pos_q;

`ifdef HAM_DEC_STATS_EN
   logic             out_fire;
   logic [CNT_W-1:0] cnt_corr_q,  cnt_corr_d;
   logic [CNT_W-1:0] cnt_total_q, cnt_total_d;

   assign out_fire = s2_vld_q & out_ready;

   // Counters stick at all-ones instead of wrapping.
   always_comb begin
      cnt_corr_d  = cnt_corr_q;
      cnt_total_d = cnt_total_q;
      if (out_fire) begin
         if (cnt_total_q != '1) begin
            cnt_total_d = cnt_total_q + CNT_W'(1);
         end
         if (s2_det_q && (cnt_corr_q != '1)) begin
            cnt_corr_d = cnt_corr_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_corr_q  <= '0;
         cnt_total_q <= '0;
      end else begin
         cnt_corr_q  <= cnt_corr_d;
         cnt_total_q <= cnt_total_d;
      end
   end

   assign cnt_corr  = cnt_corr_q;
   assign cnt_total = cnt_total_q;
`endif

endmodule

// File: tb/tb_ham_15_11_syndrome_decoder.sv
// Directed bench for ham_15_11_syndrome_decoder with a position-arithmetic reference model
// and a scoreboard; counter checks compile in when HAM_DEC_STATS_EN is defined.
module tb_ham_15_11_syndrome_decoder;

`ifdef HAM_DEC_STATS_EN
   localparam int CNT_W = 2;
`else
   localparam int CNT_W = 16;
`endif

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [14:0] c_in;
   logic        out_valid;
   logic        out_ready;
   logic [10:0] d_out;
   logic        err_det;
   logic [3:0]  err_pos;
`ifdef HAM_DEC_STATS_EN
   logic [CNT_W-1:0] cnt_corr;
   logic [CNT_W-1:0] cnt_total;
`endif

   ham_15_11_syndrome_decoder #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d_out     (d_out),
      .err_det   (err_det),
      .err_pos   (err_pos)
`ifdef HAM_DEC_STATS_EN
      ,
      .cnt_corr  (cnt_corr),
      .cnt_total (cnt_total)
`endif
   );

   // clock / cycle counter
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Reference: syndrome is the XOR of the 1-based positions of all set bits;
   // data bits are the non-power-of-two positions in ascending order.
   function automatic logic [15:0] model(input logic [14:0] c_rx);
      logic [14:0] c;
      logic [10:0] d;
      int s;
      int j;
      c = c_rx;
      s = 0;
      for (int i = 0; i < 15; i++) if (c[i]) s = s ^ (i + 1);
      if (s != 0) c[s-1] = ~c[s-1];
      d = '0;
      j = 0;
      for (int p = 1; p <= 15; p++) begin
         if ((p & (p - 1)) != 0) begin
            d[j] = c[p-1];
            j++;
         end
      end
      return {d, (s != 0), 4'(s)};
   endfunction

   // scoreboard
   logic [15:0] exp_q[$];
   int          acc_q[$];
   logic        chk_lat = 1'b1;
   logic        prev_stall = 1'b0;
   logic [15:0] prev_out;
   logic [15:0] last_out = '0;
   int          n_out = 0;
   int          m_total = 0;
   int          m_corr = 0;
   int          cnt_max;

   initial cnt_max = (1 << CNT_W) - 1;

   always @(negedge clk) begin
      logic [15:0] e;
      int a;
      if (rst) begin
         exp_q.delete();
         acc_q.delete();
         prev_stall = 1'b0;
         m_total = 0;
         m_corr = 0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", {31'b0, out_valid}, 32'd1);
            check("stall_hold", {16'b0, d_out, err_det, err_pos}, {16'b0, prev_out});
         end
`ifdef HAM_DEC_STATS_EN
         check("cnt_total", {{(32-CNT_W){1'b0}}, cnt_total}, m_total);
         check("cnt_corr", {{(32-CNT_W){1'b0}}, cnt_corr}, m_corr);
`endif
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", {16'b0, d_out, err_det, err_pos}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               a = acc_q.pop_front();
               check("out_word", {16'b0, d_out, err_det, err_pos}, {16'b0, e});
               if (chk_lat) check("latency", cyc - a, 32'd2);
            end
            last_out = {d_out, err_det, err_pos};
            n_out++;
            if (m_total < cnt_max) m_total++;
            if (err_det && m_corr < cnt_max) m_corr++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(c_in));
            acc_q.push_back(cyc);
         end
         prev_stall = out_valid && !out_ready;
         prev_out = {d_out, err_det, err_pos};
      end
   end

   // driver tasks
   task automatic send(input logic [14:0] c);
      int n;
      n = 0;
      in_valid = 1'b1;
      c_in = c;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("send_timeout", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("drain", exp_q.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation timed out");
      $fatal(1, "timeout");
   end

   initial begin
      int base;
      rst = 1'b1;
      in_valid = 1'b0;
      c_in = '0;
      out_ready = 1'b1;

      // model pins
      check("model_7fff", {16'b0, model(15'h7FFF)}, {16'b0, 11'h7FF, 1'b0, 4'd0});
      check("model_0027", {16'b0, model(15'h0027)}, {16'b0, 11'h001, 1'b1, 4'd6});
      check("model_008b", {16'b0, model(15'h008B)}, {16'b0, 11'h400, 1'b1, 4'd15});
      check("model_0087", {16'b0, model(15'h0087)}, {16'b0, 11'h001, 1'b1, 4'd8});

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_outputs", {16'b0, d_out, err_det, err_pos}, 32'd0);
`ifdef HAM_DEC_STATS_EN
      check("rst_counters", {cnt_corr, cnt_total}, 0);
`endif
      @(posedge clk);
      #1;

      // clean words back-to-back
      send(15'h0000);
      send(15'h7FFF);
      send(15'h0007);
      wait_drain();
      check("clean_last", {16'b0, last_out}, {16'b0, 11'h001, 1'b0, 4'd0});

      // single-bit errors
      send(15'h0027);
      wait_drain();
      check("data_err", {16'b0, last_out}, {16'b0, 11'h001, 1'b1, 4'd6});
      send(15'h008B);
      wait_drain();
      check("msb_err", {16'b0, last_out}, {16'b0, 11'h400, 1'b1, 4'd15});
      send(15'h0087);
      wait_drain();
      check("parity_err", {16'b0, last_out}, {16'b0, 11'h001, 1'b1, 4'd8});

      // backpressure: 4 words, out_ready low for 5 cycles
      chk_lat = 1'b0;
      out_ready = 1'b0;
      base = n_out;
      fork
         begin
            send(15'h0007);
            send(15'h0027);
            send(15'h7FFF);
            send(15'h008B);
         end
         begin
            repeat (3) @(negedge clk);
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      wait_drain();
      check("bp_count", n_out - base, 32'd4);
      check("bp_last", {16'b0, last_out}, {16'b0, 11'h400, 1'b1, 4'd15});
      chk_lat = 1'b1;

      // reset with two words in flight
      out_ready = 1'b0;
      base = n_out;
      send(15'h0000);
      send(15'h0027);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
      out_ready = 1'b1;
      repeat (6) @(negedge clk);
      check("midrst_no_out", n_out - base, 32'd0);
      @(posedge clk);
      #1;

      // erroneous words for statistics
      base = n_out;
      send(15'h0027);
      send(15'h008B);
      send(15'h0087);
      send(15'h0006);
      send(15'h7FFE);
      wait_drain();
      check("stats_words", n_out - base, 32'd5);
      check("stats_last", {16'b0, last_out}, {16'b0, 11'h7FF, 1'b1, 4'd1});
`ifdef HAM_DEC_STATS_EN
      @(negedge clk);
      check("sat_total", {30'b0, cnt_total}, 32'd3);
      check("sat_corr", {30'b0, cnt_corr}, 32'd3);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ham_15_11_syndrome_decoder.md
Name: ham_15_11_syndrome_decoder

Overview:
- Receive-side counterpart of the team's Hamming(15,11) encoder.
- Accepts 15-bit codewords, computes the 4-bit syndrome, corrects any single-bit error and returns the 11 data bits with error status.
- Two-stage pipeline with valid/ready handshakes on both sides, so it can sit directly behind a channel/storage model with backpressure.

Parameters:
- CNT_W, 16, width of the saturating error-statistics counters (optional feature only).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  c_in holds a codeword.
- in_ready  output  1  decoder accepts c_in this cycle.
- c_in  input  15  received codeword, same bit map as the encoder.
- out_valid  output  1  d_out/status valid.
- out_ready  input  1  downstream accepts output.
- d_out  output  11  corrected data.
- err_det  output  1  syndrome was nonzero.
- err_pos  output  4  syndrome value = 1-based position of the flipped bit; 0 means no error.
- cnt_corr  output  CNT_W  count of corrected words (present only with macro).
- cnt_total  output  CNT_W  count of words delivered (present only with macro).

Behaviour:
- Bit map: c[i] is position i+1. Parity bits sit at c[0], c[1], c[3], c[7] (positions 1,2,4,8). Data sits at c[2]=d0, c[4..6]=d1..d3, c[8..14]=d4..d10.
- Syndrome: s[k] = XOR of all c[i] where bit k of (i+1) is 1, for k=0..3.
- Correction: if s≠0, invert c[s-1], then extract d. Every nonzero syndrome (1..15) is treated as a single error, including parity-bit positions. For positions 1,2,4,8 the data is unchanged but err_det is still 1.
- Stage 1 (S1) registers c_in and the computed syndrome on an in_valid && in_ready handshake.
- Stage 2 (S2) registers the corrected d_out, err_det and err_pos.
- Latency: 2 cycles from accept to out_valid when not stalled. Sustained throughput is 1 word per cycle.
- Handshake:
  - s2_adv = ~s2_vld | out_ready.
  - s1_adv = ~s1_vld | s2_adv.
  - in_ready = s1_adv, combinational, with no dependency on in_valid.
  - S2 loads when s1_vld && s2_adv; otherwise, if out_ready, s2_vld clears.
  - S1 loads on accept; otherwise, if s2_adv, s1_vld clears.
- While out_valid && !out_ready, d_out, err_det and err_pos stay stable.
- Simultaneous consume and refill in the same cycle involves no bubble.
- Reset:
  - s1_vld, s2_vld, out_valid = 0; d_out = 0, err_det = 0, err_pos = 0; counters = 0.
  - in_ready is 1 during the first cycle after reset.
  - Reset mid-operation discards in-flight words; none are emitted afterwards.
- in_valid is ignored while in_ready = 0. The source must hold c_in stable until accepted.

Optional Feature:
- Macro HAM_DEC_STATS_EN.
- Defined:
  - cnt_total increments on each out_valid && out_ready.
  - cnt_corr increments on the same handshake when err_det = 1.
  - Both saturate at 2^CNT_W-1 and do not wrap.
  - Both clear on rst.
- Undefined: the cnt_* ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Clean words, out_ready=1: c_in 15'h0000, 15'h7FFF, 15'h0007 back-to-back:
  - d_out 11'h000, 11'h7FF, 11'h001 on consecutive cycles starting 2 cycles after the first accept.
  - err_det=0, err_pos=0.
- Data error: c_in 15'h0027 (codeword 0x0007 with c[5] flipped) -> d_out 11'h001, err_det=1, err_pos=6.
- MSB error: c_in 15'h008B (codeword 0x408B with c[14] flipped) -> d_out 11'h400, err_pos=15.
- Parity-bit error: c_in 15'h0087 (codeword 0x0007 with c[7] flipped) -> d_out 11'h001, err_pos=8.
- Backpressure: stream 4 words with out_ready held 0 for 5 cycles.
  - in_ready drops after 2 accepts; out_valid/d_out hold.
  - On release, all 4 words emerge in order with none lost or duplicated.
- Reset and stats: assert rst with 2 words in flight -> out_valid=0 next cycle and nothing emitted afterwards. With HAM_DEC_STATS_EN and CNT_W=2, send 5 erroneous words -> cnt_corr and cnt_total saturate at 3.
